// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM states, vector addresses
// and the opcode-length helper also used by decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_RST,
    RUN,
    IMM,
    VEC_INT
  } state_t;

  localparam logic [7:0] RST_VEC_DEF = 8'h00;
  localparam logic [7:0] INT_VEC_DEF = 8'h01;
  localparam logic [3:0] IMM_GRP     = 4'hC;

  function automatic logic needs_imm(input logic [7:0] opcode);
    return opcode[7:4] == IMM_GRP;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus plus the IF/ID-bound instruction bundle.
// master = fetch stage, slave = memory / pipeline register side.
interface fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] immediate;
  logic              immediate_en;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output instr,
    output immediate,
    output immediate_en,
    output instr_valid,
    output pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  instr,
    input  immediate,
    input  immediate_en,
    input  instr_valid,
    input  pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, vector loads,
// 1/2-byte instruction assembly, redirects and interrupt entry.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RST_VEC = RST_VEC_DEF,
  parameter logic [ADDR_W-1:0] INT_VEC = INT_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              intr_req,
  input  logic              intr_ret,
  fetch_if.master           bus,
  output logic [ADDR_W-1:0] ret_pc,
  output logic              intr_ack,
  output logic              intr_active
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              pend_q, pend_d;
  logic              act_d;
  logic [ADDR_W-1:0] ret_d;

  logic hold;
  logic take_int;
  logic two_byte;

  assign two_byte = needs_imm(bus.imem_rdata);
  assign hold     = f_stall & ~branch_taken
                  & (state_q != VEC_RST);
  assign take_int = (state_q == RUN) & pend_q
                  & ~f_stall & ~branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= VEC_RST;
      pc_q        <= '0;
      op_q        <= '0;
      pend_q      <= 1'b0;
      intr_active <= 1'b0;
      ret_pc      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      intr_active <= act_d;
      ret_pc      <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    pend_d  = pend_q;
    act_d   = intr_active;
    ret_d   = ret_pc;
    if (!hold)
      pend_d = pend_q | (intr_req & ~intr_active);
    if (intr_ret)
      act_d = 1'b0;
    if (state_q == VEC_RST) begin
      pc_d    = bus.imem_rdata;
      state_d = RUN;
    end else if (branch_taken) begin
      pc_d    = branch_target;
      state_d = RUN;
    end else if (!f_stall) begin
      unique case (state_q)
        RUN: begin
          if (pend_q) begin
            ret_d   = pc_q;
            state_d = VEC_INT;
          end else if (two_byte) begin
            op_d    = bus.imem_rdata;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = IMM;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
        IMM: begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = RUN;
        end
        VEC_INT: begin
          pc_d    = bus.imem_rdata;
          pend_d  = 1'b0;
          act_d   = 1'b1;
          state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  // Outputs describe the fetch under way; IF/ID does the holding.
  always_comb begin
    bus.imem_addr    = '0;
    bus.instr        = '0;
    bus.immediate    = '0;
    bus.immediate_en = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.pc           = '0;
    intr_ack         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        VEC_RST: bus.imem_addr = RST_VEC;
        RUN: begin
          bus.imem_addr   = pc_q;
          bus.pc          = pc_q;
          bus.instr       = bus.imem_rdata;
          bus.instr_valid = ~two_byte & ~branch_taken
                          & ~take_int;
        end
        IMM: begin
          bus.imem_addr    = pc_q;
          bus.pc           = pc_q - ADDR_W'(1);
          bus.instr        = op_q;
          bus.immediate    = bus.imem_rdata;
          bus.immediate_en = 1'b1;
          bus.instr_valid  = ~branch_taken;
        end
        VEC_INT: begin
          bus.imem_addr = INT_VEC;
          intr_ack      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit against a small
// combinational memory image.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [4:0] ctl;
    logic [7:0] tgt;
    logic [3:0] flg;
    logic [7:0] addr;
    logic [7:0] ins;
    logic [7:0] imm;
    logic [7:0] pc;
    logic [7:0] ret;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       f_stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       intr_req;
  logic       intr_ret;
  logic [7:0] ret_pc;
  logic       intr_ack;
  logic       intr_active;

  logic [7:0] mem [256];
  int total;
  int bad;

  fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  assign bus.imem_rdata = mem[bus.imem_addr];

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .f_stall      (f_stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .intr_req     (intr_req),
    .intr_ret     (intr_ret),
    .bus          (bus.master),
    .ret_pc       (ret_pc),
    .intr_ack     (intr_ack),
    .intr_active  (intr_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h",
               nm, idx, act, exp);
    end
  endtask

  // ctl = {reset, stall, branch, intr_req, intr_ret}
  // flg = {valid, imm_en, intr_ack, intr_active}
  task automatic step(input vec_t v, input int idx);
    {reset, f_stall, branch_taken,
     intr_req, intr_ret} = v.ctl;
    branch_target = v.tgt;
    @(negedge clk);
    chk("addr", idx, bus.imem_addr, v.addr);
    chk("valid", idx, 8'(bus.instr_valid), 8'(v.flg[3]));
    chk("ack", idx, 8'(intr_ack), 8'(v.flg[1]));
    chk("active", idx, 8'(intr_active), 8'(v.flg[0]));
    chk("ret_pc", idx, ret_pc, v.ret);
    if (v.flg[3]) begin
      chk("instr", idx, bus.instr, v.ins);
      chk("imm", idx, bus.immediate, v.imm);
      chk("imm_en", idx, 8'(bus.immediate_en), 8'(v.flg[2]));
      chk("pc", idx, bus.pc, v.pc);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tv [36];
  vec_t hs [8];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    f_stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    intr_req = 1'b0;
    intr_ret = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h80;
    mem[8'h10] = 8'h20;
    mem[8'h11] = 8'hC1;
    mem[8'h12] = 8'h55;
    mem[8'h13] = 8'h30;
    mem[8'h80] = 8'h40;

    // reset, basic fetch
    tv[0]  = '{5'b10000, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[1]  = '{5'b00000, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[2]  = '{5'b00000, 8'h00, 4'b1000, 8'h10, 8'h20, 8'h00, 8'h10, 8'h00};
    tv[3]  = '{5'b00000, 8'h00, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[4]  = '{5'b00000, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h00};
    tv[5]  = '{5'b00000, 8'h00, 4'b1000, 8'h13, 8'h30, 8'h00, 8'h13, 8'h00};
    // stall in IMM
    tv[6]  = '{5'b00100, 8'h11, 4'b0000, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[7]  = '{5'b00000, 8'h00, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[8]  = '{5'b01000, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h00};
    tv[9]  = '{5'b01000, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h00};
    tv[10] = '{5'b01000, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h00};
    tv[11] = '{5'b00000, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h00};
    tv[12] = '{5'b00000, 8'h00, 4'b1000, 8'h13, 8'h30, 8'h00, 8'h13, 8'h00};
    // branch in IMM
    tv[13] = '{5'b00100, 8'h11, 4'b0000, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[14] = '{5'b00000, 8'h00, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[15] = '{5'b00100, 8'h80, 4'b0000, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[16] = '{5'b00000, 8'h00, 4'b1000, 8'h80, 8'h40, 8'h00, 8'h80, 8'h00};
    // interrupt at pc 13, nested request ignored, RTI
    tv[17] = '{5'b00110, 8'h13, 4'b0000, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[18] = '{5'b00000, 8'h00, 4'b0000, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[19] = '{5'b00000, 8'h00, 4'b0010, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[20] = '{5'b00010, 8'h00, 4'b1001, 8'h80, 8'h40, 8'h00, 8'h80, 8'h13};
    tv[21] = '{5'b00000, 8'h00, 4'b1001, 8'h81, 8'h00, 8'h00, 8'h81, 8'h13};
    tv[22] = '{5'b00001, 8'h00, 4'b1001, 8'h82, 8'h00, 8'h00, 8'h82, 8'h13};
    tv[23] = '{5'b00000, 8'h00, 4'b1000, 8'h83, 8'h00, 8'h00, 8'h83, 8'h13};
    tv[24] = '{5'b00000, 8'h00, 4'b1000, 8'h84, 8'h00, 8'h00, 8'h84, 8'h13};
    // request in IMM waits for the boundary
    tv[25] = '{5'b00100, 8'h11, 4'b0000, 8'h85, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[26] = '{5'b00000, 8'h00, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[27] = '{5'b00010, 8'h00, 4'b1100, 8'h12, 8'hC1, 8'h55, 8'h11, 8'h13};
    tv[28] = '{5'b00000, 8'h00, 4'b0000, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[29] = '{5'b00000, 8'h00, 4'b0010, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[30] = '{5'b00000, 8'h00, 4'b1001, 8'h80, 8'h40, 8'h00, 8'h80, 8'h13};
    // RTI with request held: pend re-arms a cycle later
    tv[31] = '{5'b00011, 8'h00, 4'b1001, 8'h81, 8'h00, 8'h00, 8'h81, 8'h13};
    tv[32] = '{5'b00010, 8'h00, 4'b1000, 8'h82, 8'h00, 8'h00, 8'h82, 8'h13};
    tv[33] = '{5'b00000, 8'h00, 4'b0000, 8'h83, 8'h00, 8'h00, 8'h00, 8'h13};
    tv[34] = '{5'b00000, 8'h00, 4'b0010, 8'h01, 8'h00, 8'h00, 8'h00, 8'h83};
    tv[35] = '{5'b00000, 8'h00, 4'b1001, 8'h80, 8'h40, 8'h00, 8'h80, 8'h83};

    // mid-handler reset, then wrap at FF with branch over stall
    hs[0] = '{5'b10000, 8'h00, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h83};
    hs[1] = '{5'b10000, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    hs[2] = '{5'b00000, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    hs[3] = '{5'b00000, 8'h00, 4'b1000, 8'h10, 8'h20, 8'h00, 8'h10, 8'h00};
    hs[4] = '{5'b01100, 8'hFF, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
    hs[5] = '{5'b00000, 8'h00, 4'b0000, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    hs[6] = '{5'b00000, 8'h00, 4'b1100, 8'h00, 8'hC2, 8'h77, 8'hFF, 8'h00};
    hs[7] = '{5'b00000, 8'h00, 4'b1000, 8'h01, 8'h80, 8'h00, 8'h01, 8'h00};

    @(posedge clk);
    #1;
    for (int i = 0; i < 36; i++) step(tv[i], i);

    for (int i = 0; i < 4; i++) step(hs[i], 100 + i);
    mem[8'h00] = 8'h77;
    mem[8'hFF] = 8'hC2;
    for (int i = 4; i < 8; i++) step(hs[i], 100 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 8-bit pipelined CPU. It owns the PC, loads the reset and interrupt vectors from memory, and assembles 1- or 2-byte instructions into opcode plus immediate. It applies branch redirects from EX and runs the interrupt-entry sequence. Its outputs feed the IF/ID pipeline register; it drives the instruction-side address of the unified memory.

Parameters:
ADDR_W, 8, PC and instruction-address width
DATA_W, 8, instruction byte width
RST_VEC, 8'h00, memory address holding the reset start PC
INT_VEC, 8'h01, memory address holding the interrupt handler PC

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
f_stall  in  1  freeze PC, state and held opcode
branch_taken  in  1  redirect request from EX
branch_target  in  ADDR_W  redirect PC
intr_req  in  1  external interrupt, level
intr_ret  in  1  one-cycle pulse from decode on RTI; clears intr_active
imem_addr  out  ADDR_W  instruction-side memory address
imem_rdata  in  DATA_W  byte at imem_addr, combinational same-cycle read
instr  out  DATA_W  opcode byte
immediate  out  DATA_W  second byte, else 0
immediate_en  out  1  instr carries an immediate
instr_valid  out  1  instr/immediate form a complete instruction this cycle
pc  out  ADDR_W  address of the instruction's first byte
ret_pc  out  ADDR_W  return address saved on interrupt entry
intr_ack  out  1  one-cycle pulse on interrupt vector fetch
intr_active  out  1  handler running

Behaviour:
- States: VEC_RST, RUN, IMM, VEC_INT. Registers: pc_q, op_q, pend, intr_active, ret_pc.
- Reset: state=VEC_RST, pc_q=0, op_q=0, pend=0, intr_active=0, ret_pc=0. All combinational outputs are 0 while reset is high.
- VEC_RST: imem_addr=RST_VEC, instr_valid=0. At the next edge, pc_q<=imem_rdata and state goes to RUN. This state ignores stall, branch and interrupt.
- RUN: imem_addr=pc_q, pc=pc_q.
  - 1-byte opcode (needs_imm false): instr=imem_rdata, immediate=0, immediate_en=0, instr_valid=1; pc_q<=pc_q+1.
  - 2-byte opcode (opcode[7:4]==4'hC): instr_valid=0; op_q<=imem_rdata, pc_q<=pc_q+1, state goes to IMM.
- IMM: imem_addr=pc_q, instr=op_q, immediate=imem_rdata, immediate_en=1, instr_valid=1, pc=pc_q-1; pc_q<=pc_q+1, state goes to RUN. Fetch latency is 1 cycle for a 1-byte instruction and 2 cycles for a 2-byte instruction.
- PC arithmetic is modulo 2^ADDR_W; 8'hFF+1 wraps to 8'h00. A 2-byte instruction at 8'hFF takes its immediate from 8'h00.
- Priority per cycle: reset > branch_taken > f_stall > interrupt entry > normal fetch.
- branch_taken (RUN, IMM or VEC_INT): pc_q<=branch_target, state goes to RUN, instr_valid=0 that cycle. Any partial 2-byte fetch is discarded. branch_taken overrides f_stall.
- f_stall (no branch): all registers hold. Combinational outputs still reflect the current fetch; the IF/ID register is responsible for holding.
- Interrupt pending: pend<=1 when intr_req=1 and intr_active=0. pend is sticky until accepted.
- Interrupt entry: taken only at an instruction boundary, i.e. state RUN with pend=1, no stall and no branch. That cycle:
  - instr_valid=0, so the fetched byte is discarded;
  - ret_pc<=pc_q, state goes to VEC_INT.
- VEC_INT: imem_addr=INT_VEC, intr_ack=1, instr_valid=0. At the next edge: pc_q<=imem_rdata, pend<=0, intr_active<=1, state goes to RUN.
- Interrupts are never accepted in the IMM state; a 2-byte instruction always completes first.
- intr_ret: intr_active<=0 at the next edge. If intr_req is still high, pend re-arms one cycle later.
- intr_req arriving while intr_active=1 is ignored (no nesting).
- Reset mid-operation (any state) returns to VEC_RST and drops any pending interrupt and held opcode.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum;
  - RST_VEC and INT_VEC defaults;
  - IMM_GRP=4'hC;
  - function needs_imm(opcode), reused by decode.
- The block is a single module; no sub-module is natural.

Test Plan:
- Common memory image: M[0]=8'h10, M[1]=8'h80, M[10..13]=20,C1,55,30, M[80]=40.
- Reset release -> cycle 0 imem_addr=00, valid=0. Cycle 1 pc=10, instr=20, valid=1, imm_en=0. Cycles 2-3: valid=0, then instr=C1, immediate=55, imm_en=1, pc=11. Cycle 4: instr=30, pc=13.
- f_stall high for 3 cycles in the IMM state at pc_q=12 -> imem_addr stays 12 and outputs stay C1/55. After release, the next instr=30 appears 1 cycle later.
- branch_taken with branch_target=80 while in IMM -> instr_valid=0 that cycle; next cycle pc=80, instr=40. The C1 instruction is never emitted.
- intr_req pulse while fetching at pc_q=13 -> valid=0, ret_pc=13. Next cycle intr_ack=1 and imem_addr=01. Then pc=80 and intr_active=1. A second intr_req while active is ignored. After an intr_ret pulse, intr_active=0.
- intr_req arriving during the IMM cycle of C1 -> C1/55 is emitted first; entry happens at the next boundary with ret_pc=13.
- M[FF]=C2, M[00]=77, branch to FF -> emits C2/77 with pc=FF, then pc_q wraps to 01.
